iter_normalizer: RTL

Sequential leading-one normalizer. It is the inverse of the barrel shifter. Given a word, it shifts the word left one bit per cycle until the MSB is 1, and reports the normalized word and the shift count. Feeding the result back through `barrel_shifter` with `dir=1` (right shift) by the reported count reproduces the original word. It sits in the datapath in front of anything that needs normalized operands, and uses a valid/ready handshake on both sides.

---
 rtl/norm_pkg.sv | 20 ++
 rtl/iter_normalizer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/norm_pkg.sv
// norm_pkg: shared definitions for the leading-one normalizer datapath.
//   - norm_state_e  : normalizer FSM states (IDLE / SHIFT / DONE)
//   - norm_shift_w  : shift-count width for a given data width; matches the
//                     barrel shifter's shift-amount width so results can be
//                     fed straight back through it (2 bits at WIDTH=4).
package norm_pkg;

    localparam int unsigned NORM_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } norm_state_e;

    function automatic int unsigned norm_shift_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/iter_normalizer.sv
// iter_normalizer: sequential leading-one normalizer. Shifts an accepted word
// left one bit per cycle until its MSB is 1, then presents the normalized word
// and the number of shifts applied. Inverse of a right barrel shift.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_data valid
//   in_ready   out  block can accept input (IDLE and not in reset)
//   in_data    in   [WIDTH-1:0] word to normalize
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts result
//   out_data   out  [WIDTH-1:0] normalized word (MSB=1 unless zero)
//   out_shift  out  [SHIFT_W-1:0] left shifts applied, 0..WIDTH-1
//   out_zero   out  input was all zeros
module iter_normalizer
    import norm_pkg::*;
#(
    parameter int unsigned WIDTH   = NORM_DEFAULT_WIDTH,
    parameter int unsigned SHIFT_W = norm_shift_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_zero
);

    norm_state_e        r_state;
    norm_state_e        w_state_nxt;

    logic [WIDTH-1:0]   r_work;
    logic [SHIFT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_out_data;
    logic [SHIFT_W-1:0] r_out_shift;
    logic               r_out_zero;

    logic               w_accept;
    logic               w_in_zero;
    logic               w_in_msb;
    logic               w_shift_last;
    logic [WIDTH-1:0]   w_work_shl;
    logic [SHIFT_W-1:0] w_cnt_inc;

    assign w_in_zero    = (in_data == '0);
    assign w_in_msb     = in_data[WIDTH-1];
    // Pre-shift bit WIDTH-2 set means this shift lands a 1 in the MSB.
    assign w_shift_last = r_work[WIDTH-2];
    assign w_work_shl   = {r_work[WIDTH-2:0], 1'b0};
    assign w_cnt_inc    = r_cnt + SHIFT_W'(1);
    assign w_accept     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // rst gates in_ready so nothing is accepted on the reset edge.
                in_ready = !rst;
                if (w_accept) begin
                    if (w_in_zero || w_in_msb) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_shift_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result registers are separate from the working register so the last
    // result stays visible while the next word is being shifted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_shift <= '0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work <= in_data;
                        r_cnt  <= '0;
                        if (w_in_zero || w_in_msb) begin
                            r_out_data  <= in_data;
                            r_out_shift <= '0;
                            r_out_zero  <= w_in_zero;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_work_shl;
                    r_cnt  <= w_cnt_inc;
                    if (w_shift_last) begin
                        r_out_data  <= w_work_shl;
                        r_out_shift <= w_cnt_inc;
                        r_out_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_shift = r_out_shift;
    assign out_zero  = r_out_zero;

endmodule
